// File: rtl/ui_asm_pkg.sv
// ui_asm_pkg: shared constants, width helpers and the default word type for
// the ui_word_assembler input stage.
`timescale 1ns/1ps
package ui_asm_pkg;

  localparam int WORD_BYTES_DEF = 4;
  localparam int DEPTH_DEF      = 4;

  typedef logic [8*WORD_BYTES_DEF-1:0] word_t;

  // Width of a word counter that must hold 0..depth inclusive.
  function automatic int fill_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Width of the byte-lane index; never below one bit.
  function automatic int idx_w(input int word_bytes);
    return (word_bytes > 1) ? $clog2(word_bytes) : 1;
  endfunction

  // Width of a FIFO pointer; depth is a power of two so pointers wrap naturally.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ui_word_assembler_if.sv
// ui_word_assembler_if: byte-side strobe bus, word-side valid/ready bus and
// status outputs of the word assembler. The slave modport is the assembler,
// the master modport is the host/consumer side.
`timescale 1ns/1ps
interface ui_word_assembler_if
  import ui_asm_pkg::*;
#(
  parameter int WORD_BYTES = WORD_BYTES_DEF,
  parameter int DEPTH      = DEPTH_DEF
);

  logic [7:0]                    byte_in;
  logic                          byte_strobe;
  logic [8*WORD_BYTES-1:0]       word_out;
  logic                          word_valid;
  logic                          word_ready;
  logic [fill_w(DEPTH)-1:0]      fill;
  logic [idx_w(WORD_BYTES)-1:0]  byte_idx;
  logic                          overflow;

  modport slave (
    input  byte_in, byte_strobe, word_ready,
    output word_out, word_valid, fill, byte_idx, overflow
  );

  modport master (
    output byte_in, byte_strobe, word_ready,
    input  word_out, word_valid, fill, byte_idx, overflow
  );

endinterface

// File: rtl/ui_asm_fifo.sv
// ui_asm_fifo: DEPTH x WIDTH register FIFO. A push into a full FIFO is only
// accepted when a pop frees a slot in the same cycle. Read data is forced to
// zero while empty so the consumer never sees stale words.
`timescale 1ns/1ps
module ui_asm_fifo
  import ui_asm_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [fill_w(DEPTH)-1:0] fill_o
);

  localparam int PW = ptr_w(DEPTH);
  localparam int FW = fill_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic             empty_s, full_s, do_push_s, do_pop_s;

  // Accept/reject decisions and next pointer/fill values; clear wins over all.
  always_comb begin
    empty_s   = (fill_q == FW'(0));
    full_s    = (fill_q == FW'(DEPTH));
    do_pop_s  = pop_i & ~empty_s & ~clr_i;
    do_push_s = push_i & ~clr_i & (~full_s | do_pop_s);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    fill_d    = fill_q;
    if (clr_i) begin
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      fill_d   = {FW{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   fill_d = fill_q + FW'(1);
        2'b01:   fill_d = fill_q - FW'(1);
        default: fill_d = fill_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      fill_q   <= {FW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
    end
  end

  // Word storage; only written on an accepted push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else if (do_push_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = empty_s ? {WIDTH{1'b0}} : mem_q[rd_ptr_q];
  assign full_o  = full_s;
  assign empty_o = empty_s;
  assign fill_o  = fill_q;

endmodule

// File: rtl/ui_word_assembler.sv
// ui_word_assembler: samples ui_in bytes on rising edges of a host strobe,
// packs them little-endian into words and queues the words for the core.
// Build option: define UI_ASM_STROBE_SYNC_EN to pass the strobe through a
// 2-flop synchronizer (adds 2 cycles of latency) when it is asynchronous.
`timescale 1ns/1ps
module ui_word_assembler
  import ui_asm_pkg::*;
#(
  parameter int WORD_BYTES = WORD_BYTES_DEF,
  parameter int DEPTH      = DEPTH_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                clr,
  ui_word_assembler_if.slave  bus
);

  localparam int IW = idx_w(WORD_BYTES);
  localparam int WW = 8 * WORD_BYTES;

  logic          strobe_s, strobe_q;
  logic          rise_s, take_s, last_s;
  logic [IW-1:0] byte_idx_q, byte_idx_d;
  logic [WW-1:0] partial_q, partial_d, merged_s;
  logic          overflow_q, overflow_d;
  logic          push_s, drop_s, full_s, empty_s;

`ifdef UI_ASM_STROBE_SYNC_EN
  logic [1:0] sync_q;

  // Two-flop synchronizer for a strobe that is asynchronous to clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], bus.byte_strobe};
    end
  end

  assign strobe_s = sync_q[1];
`else
  assign strobe_s = bus.byte_strobe;
`endif

  // Strobe delay for edge detection; keeps tracking through clr and ena low
  // so a held strobe never produces a second byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= strobe_s;
    end
  end

  // Byte capture, word completion and overflow tracking.
  always_comb begin
    rise_s     = strobe_s & ~strobe_q;
    take_s     = rise_s & ena & ~clr;
    last_s     = (byte_idx_q == IW'(WORD_BYTES - 1));
    merged_s   = partial_q;
    merged_s[{byte_idx_q, 3'b000} +: 8] = bus.byte_in;
    push_s     = take_s & last_s;
    // A completed word is lost only if no slot frees up this cycle.
    drop_s     = push_s & full_s & ~(bus.word_ready & ~empty_s);
    byte_idx_d = byte_idx_q;
    partial_d  = partial_q;
    overflow_d = overflow_q;
    if (clr) begin
      byte_idx_d = {IW{1'b0}};
      partial_d  = {WW{1'b0}};
      overflow_d = 1'b0;
    end else begin
      if (take_s && last_s) begin
        byte_idx_d = {IW{1'b0}};
        partial_d  = {WW{1'b0}};
      end else if (take_s) begin
        byte_idx_d = byte_idx_q + IW'(1);
        partial_d  = merged_s;
      end else begin
        byte_idx_d = byte_idx_q;
        partial_d  = partial_q;
      end
      overflow_d = overflow_q | drop_s;
    end
  end

  // Partial word, lane index and sticky overflow registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx_q <= {IW{1'b0}};
      partial_q  <= {WW{1'b0}};
      overflow_q <= 1'b0;
    end else begin
      byte_idx_q <= byte_idx_d;
      partial_q  <= partial_d;
      overflow_q <= overflow_d;
    end
  end

  ui_asm_fifo #(
    .WIDTH (WW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (clr),
    .push_i  (push_s),
    .pop_i   (bus.word_ready),
    .wdata_i (merged_s),
    .rdata_o (bus.word_out),
    .full_o  (full_s),
    .empty_o (empty_s),
    .fill_o  (bus.fill)
  );

  assign bus.word_valid = ~empty_s;
  assign bus.byte_idx   = byte_idx_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_ui_word_assembler.sv
// tb_ui_word_assembler: directed stimulus for ui_word_assembler (4 bytes x 4
// words). Expected words go into a queue when their last byte is issued; a
// separate monitor pops and compares on every accepted handshake.
`timescale 1ns/1ps
module tb_ui_word_assembler;
  import ui_asm_pkg::*;

  localparam int WB = 4;
  localparam int DP = 4;
`ifdef UI_ASM_STROBE_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic ena   = 1'b0;
  logic clr   = 1'b0;

  int    n_vec = 0;
  int    n_err = 0;
  word_t exp_q [$];
  word_t exp_w;
  word_t wl [5];

  ui_word_assembler_if #(.WORD_BYTES(WB), .DEPTH(DP)) bus ();

  ui_word_assembler #(.WORD_BYTES(WB), .DEPTH(DP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .clr   (clr),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted handshake must present the oldest expected word.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && clr === 1'b0 && bus.word_valid === 1'b1 && bus.word_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_pop: got %0h, want no word", bus.word_out);
      end else begin
        exp_w = exp_q.pop_front();
        chk("pop_word", {32'h0, bus.word_out}, {32'h0, exp_w});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit pop_on_rise);
    bus.byte_in     = b;
    bus.byte_strobe = 1'b1;
    repeat (LAT) tick();
    if (pop_on_rise) bus.word_ready = 1'b1;
    tick();
    bus.word_ready  = 1'b0;
    bus.byte_strobe = 1'b0;
    repeat (1 + LAT) tick();
  endtask

  task automatic send_word(input word_t w, input bit pop_on_last);
    for (int i = 0; i < WB; i++) begin
      send_byte(w[8*i +: 8], pop_on_last && (i == WB - 1));
    end
  endtask

  task automatic drain_one();
    bus.word_ready = 1'b1;
    tick();
    bus.word_ready = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    wl[0] = 32'h0403_0201;
    wl[1] = 32'h0807_0605;
    wl[2] = 32'h0C0B_0A09;
    wl[3] = 32'h100F_0E0D;
    wl[4] = 32'h1413_1211;
    bus.byte_in     = 8'h00;
    bus.byte_strobe = 1'b0;
    bus.word_ready  = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_word_out", bus.word_out, 0);
    chk("rst_word_valid", bus.word_valid, 0);
    chk("rst_fill", bus.fill, 0);
    chk("rst_byte_idx", bus.byte_idx, 0);
    chk("rst_overflow", bus.overflow, 0);
    rst_n = 1'b1;
    ena   = 1'b1;
    tick();

    // Basic assembly: 11 22 33 44
    exp_q.push_back(32'h4433_2211);
    send_word(32'h4433_2211, 1'b0);
    chk("s1_word_out", bus.word_out, 32'h4433_2211);
    chk("s1_word_valid", bus.word_valid, 1);
    chk("s1_fill", bus.fill, 1);
    chk("s1_byte_idx", bus.byte_idx, 0);
    drain_one();
    chk("s1_fill_after_pop", bus.fill, 0);
    chk("s1_valid_after_pop", bus.word_valid, 0);

    // Overflow: five words, no consumer
    for (int i = 0; i < 5; i++) begin
      if (i < 4) exp_q.push_back(wl[i]);
      send_word(wl[i], 1'b0);
      if (i == 3) chk("s2_no_ovf_at_full", bus.overflow, 0);
    end
    chk("s2_fill", bus.fill, 4);
    chk("s2_overflow", bus.overflow, 1);
    chk("s2_head", bus.word_out, wl[0]);
    pulse_clr();
    exp_q.delete();
    chk("s2_clr_fill", bus.fill, 0);
    chk("s2_clr_overflow", bus.overflow, 0);
    chk("s2_clr_word_out", bus.word_out, 0);
    chk("s2_clr_valid", bus.word_valid, 0);

    // Full FIFO with pop coinciding with the push
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(wl[i]);
      send_word(wl[i], 1'b0);
    end
    exp_q.push_back(wl[4]);
    send_word(wl[4], 1'b1);
    chk("s3_fill", bus.fill, 4);
    chk("s3_overflow", bus.overflow, 0);
    chk("s3_head", bus.word_out, wl[1]);
    repeat (4) drain_one();
    chk("s3_fill_drained", bus.fill, 0);

    // Clear of a partial word
    send_byte(8'hA0, 1'b0);
    send_byte(8'hA1, 1'b0);
    chk("s4_byte_idx", bus.byte_idx, 2);
    pulse_clr();
    chk("s4_clr_byte_idx", bus.byte_idx, 0);
    exp_q.push_back(32'hA3A2_A1A0);
    send_word(32'hA3A2_A1A0, 1'b0);
    chk("s4_word_out", bus.word_out, 32'hA3A2_A1A0);
    chk("s4_fill", bus.fill, 1);
    drain_one();

    // Held strobe yields one byte; ignored while ena is low
    bus.byte_in     = 8'h5A;
    bus.byte_strobe = 1'b1;
    repeat (10) tick();
    bus.byte_strobe = 1'b0;
    repeat (2 + LAT) tick();
    chk("s5_held_byte_idx", bus.byte_idx, 1);
    ena             = 1'b0;
    bus.byte_in     = 8'hC3;
    bus.byte_strobe = 1'b1;
    repeat (10) tick();
    bus.byte_strobe = 1'b0;
    repeat (2 + LAT) tick();
    chk("s5_ena0_byte_idx", bus.byte_idx, 1);
    chk("s5_ena0_fill", bus.fill, 0);
    ena = 1'b1;
    exp_q.push_back(32'h0302_015A);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b0);
    chk("s5_word_out", bus.word_out, 32'h0302_015A);
    chk("s5_byte_idx", bus.byte_idx, 0);
    drain_one();

    // Asynchronous reset mid-word
    send_word(wl[0], 1'b0);
    send_word(wl[1], 1'b0);
    send_byte(8'hEE, 1'b0);
    chk("s6_fill_pre", bus.fill, 2);
    chk("s6_idx_pre", bus.byte_idx, 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s6_async_word_out", bus.word_out, 0);
    chk("s6_async_valid", bus.word_valid, 0);
    chk("s6_async_fill", bus.fill, 0);
    chk("s6_async_byte_idx", bus.byte_idx, 0);
    chk("s6_async_overflow", bus.overflow, 0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    exp_q.push_back(32'hCAFE_BABE);
    send_word(32'hCAFE_BABE, 1'b0);
    chk("s6_post_word_out", bus.word_out, 32'hCAFE_BABE);
    drain_one();

    chk("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
